// File: rtl/vec_collect_pkg.sv
// Shared types and helpers for the vector collector and the tree-reduction blocks.
// clog2 returns the bit count of its argument, so clog2(8) = 4.
package vec_collect_pkg;

    typedef enum logic [0:0] {
        ST_FILL = 1'b0,
        ST_FULL = 1'b1
    } fill_state_t;

    function automatic int clog2(input int value);
        int bits;
        bits = 0;
        for (int i = 0; i < 32; i++) begin
            if ((value >> i) != 0) begin
                bits = i + 1;
            end else begin
                bits = bits;
            end
        end
        return bits;
    endfunction

endpackage

// File: rtl/vec_out_reg.sv
// Output vector register with a valid/ready handshake.
// A load sets oND; a transfer without a simultaneous load clears it.
module vec_out_reg #(
    parameter int NEl  = 8,
    parameter int BWID = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [BWID*NEl-1:0]   frame,
    input  logic                  iReady,
    output logic [BWID*NEl-1:0]   oVData,
    output logic                  oND
);

    logic [BWID*NEl-1:0] vdata_r;
    logic                nd_r;

    // Holds the vector until the downstream takes it
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vdata_r <= '0;
            nd_r    <= 1'b0;
        end else if (load) begin
            vdata_r <= frame;
            nd_r    <= 1'b1;
        end else if (iReady) begin
            nd_r    <= 1'b0;
        end
    end

    assign oVData = vdata_r;
    assign oND    = nd_r;

endmodule

// File: rtl/vec_collect.sv
// Collects NEl consecutive samples into one packed vector, with frame-start
// resynchronisation and a one-deep hold stage when the output is occupied.
module vec_collect
    import vec_collect_pkg::*;
#(
    parameter int  NEl  = 8,
    parameter int  BWID = 16,
    localparam int IWID = clog2(NEl)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [BWID-1:0]       iData,
    input  logic                  iValid,
    input  logic                  iSOF,
    output logic                  oReady,
    output logic [BWID*NEl-1:0]   oVData,
    output logic [IWID*NEl-1:0]   oVIndx,
    output logic                  oND,
    input  logic                  iReady,
    output logic                  oDrop
);

    localparam logic [IWID-1:0] LAST_IDX = IWID'(NEl - 1);
    localparam logic [IWID-1:0] ONE_IDX  = IWID'(1);
    localparam logic [IWID-1:0] ZERO_IDX = IWID'(0);

    fill_state_t                  state_r, state_s;
    logic [NEl-1:0][BWID-1:0]     fill_r, frame_s;
    logic [IWID-1:0]              cnt_r, cnt_s, idx_s;
    logic                         drop_r, drop_s;
    logic                         accept_s, wr_s, load_s, free_s;

    assign accept_s = iValid && (state_r == ST_FILL);
    // The output can take a frame this edge if it is empty or being drained
    assign free_s   = !oND || iReady;

    // Next-state, write index and frame-move decision
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        drop_s  = 1'b0;
        load_s  = 1'b0;
        wr_s    = 1'b0;
        idx_s   = cnt_r;
        case (state_r)
            ST_FILL: begin
                if (accept_s) begin
                    wr_s = 1'b1;
                    if (iSOF) begin
                        idx_s  = ZERO_IDX;
                        drop_s = (cnt_r != ZERO_IDX);
                    end else begin
                        idx_s  = cnt_r;
                    end
                    if (idx_s == LAST_IDX) begin
                        if (free_s) begin
                            load_s = 1'b1;
                            cnt_s  = ZERO_IDX;
                        end else begin
                            state_s = ST_FULL;
                            cnt_s   = LAST_IDX;
                        end
                    end else begin
                        cnt_s = idx_s + ONE_IDX;
                    end
                end else begin
                    cnt_s = cnt_r;
                end
            end
            ST_FULL: begin
                if (!oND) begin
                    load_s  = 1'b1;
                    cnt_s   = ZERO_IDX;
                    state_s = ST_FILL;
                end else begin
                    state_s = ST_FULL;
                end
            end
            default: begin
                state_s = ST_FILL;
                cnt_s   = ZERO_IDX;
            end
        endcase
    end

    // Fill register with the incoming sample merged in, so a completing
    // frame can move to the output on the same edge
    always_comb begin
        frame_s = fill_r;
        for (int k = 0; k < NEl; k++) begin
            if (wr_s && (idx_s == k[IWID-1:0])) begin
                frame_s[k] = iData;
            end else begin
                frame_s[k] = fill_r[k];
            end
        end
    end

    // Controller state, element counter, fill register and drop pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_FILL;
            cnt_r   <= ZERO_IDX;
            fill_r  <= '0;
            drop_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            fill_r  <= frame_s;
            drop_r  <= drop_s;
        end
    end

    vec_out_reg #(
        .NEl  (NEl),
        .BWID (BWID)
    ) u_out (
        .clk    (clk),
        .rst    (rst),
        .load   (load_s),
        .frame  (frame_s),
        .iReady (iReady),
        .oVData (oVData),
        .oND    (oND)
    );

    for (genvar k = 0; k < NEl; k++) begin : g_indx
        assign oVIndx[IWID*k +: IWID] = IWID'(k);
    end

    assign oReady = (state_r == ST_FILL);
    assign oDrop  = drop_r;

endmodule

// File: tb/tb_vec_collect.sv
// Self-checking bench for vec_collect (NEl=8, BWID=16): directed scenarios
// followed by random traffic, all compared against a queue-based frame model.
module tb_vec_collect;

    localparam int NE = 8;
    localparam int BW = 16;
    localparam int IW = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic [BW-1:0]     iData;
    logic              iValid, iSOF, iReady;
    logic              oReady, oND, oDrop;
    logic [BW*NE-1:0]  oVData;
    logic [IW*NE-1:0]  oVIndx;

    int tests = 0;
    int fails = 0;

    // Reference model: partial frame as a queue, one held frame, output vector
    logic [BW-1:0]     part_q[$];
    logic [BW*NE-1:0]  held_m, out_m, exp_indx;
    bit                held_v, nd_m, drop_m;

    vec_collect #(.NEl(NE), .BWID(BW)) dut (
        .clk(clk), .rst(rst), .iData(iData), .iValid(iValid), .iSOF(iSOF),
        .oReady(oReady), .oVData(oVData), .oVIndx(oVIndx), .oND(oND),
        .iReady(iReady), .oDrop(oDrop)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [BW*NE-1:0] obs, input logic [BW*NE-1:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        check("ready", {127'd0, oReady}, {127'd0, !held_v});
        check("nd",    {127'd0, oND},    {127'd0, nd_m});
        check("drop",  {127'd0, oDrop},  {127'd0, drop_m});
        check("vdata", oVData, out_m);
        check("vindx", {96'd0, oVIndx}, exp_indx);
    endtask

    task automatic model_reset();
        part_q.delete();
        held_v = 1'b0;
        nd_m   = 1'b0;
        drop_m = 1'b0;
        out_m  = '0;
        held_m = '0;
    endtask

    task automatic model_update(input logic v, input logic [BW-1:0] d, input logic s, input logic r);
        bit               nxt_nd;
        logic [BW*NE-1:0] vec;
        nxt_nd = nd_m && !r;
        drop_m = 1'b0;
        if (held_v) begin
            if (!nd_m) begin
                out_m  = held_m;
                nxt_nd = 1'b1;
                held_v = 1'b0;
            end
        end else if (v) begin
            if (s) begin
                if (part_q.size() > 0) drop_m = 1'b1;
                part_q.delete();
            end
            part_q.push_back(d);
            if (part_q.size() == NE) begin
                vec = '0;
                for (int k = 0; k < NE; k++) vec[k*BW +: BW] = part_q[k];
                if (!nd_m || r) begin
                    out_m  = vec;
                    nxt_nd = 1'b1;
                end else begin
                    held_m = vec;
                    held_v = 1'b1;
                end
                part_q.delete();
            end
        end
        nd_m = nxt_nd;
    endtask

    task automatic step(input logic v, input logic [BW-1:0] d, input logic s, input logic r);
        iValid = v;
        iData  = d;
        iSOF   = s;
        iReady = r;
        @(posedge clk);
        model_update(v, d, s, r);
        #1;
        check_all();
    endtask

    task automatic do_reset();
        iValid = 1'b0;
        iSOF   = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check_all();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    logic [BW*NE-1:0] exp_vec;
    int               nvec;
    int               guard;
    int               val;
    bit               acc;

    initial begin
        for (int k = 0; k < NE; k++) exp_indx[k*BW/4 +: IW] = k[IW-1:0];
        exp_indx[BW*NE-1:IW*NE] = '0;
        rst = 1'b0; iValid = 1'b0; iSOF = 1'b0; iReady = 1'b0; iData = '0;
        model_reset();
        #3;
        do_reset();

        // Eight samples back to back
        for (int i = 1; i <= NE; i++) step(1'b1, BW'(i), 1'b0, 1'b1);
        for (int k = 0; k < NE; k++) exp_vec[k*BW +: BW] = BW'(k + 1);
        check("bb_nd", {127'd0, oND}, 128'd1);
        check("bb_vec", oVData, exp_vec);
        step(1'b0, 16'h0000, 1'b0, 1'b1);

        // Backpressure: sixteen samples offered with iReady low
        val = 1; guard = 0;
        while (val <= 16 && guard < 100) begin
            acc = !held_v;
            step(1'b1, BW'(val), 1'b0, 1'b0);
            if (acc) val++;
            guard++;
        end
        check("bp_guard", {96'd0, 32'(val)}, 128'd17);
        check("bp_ready_low", {127'd0, oReady}, 128'd0);
        step(1'b0, 16'h0000, 1'b0, 1'b0);
        check("bp_vec1", oVData, exp_vec);
        step(1'b0, 16'h0000, 1'b0, 1'b1);
        step(1'b0, 16'h0000, 1'b0, 1'b1);
        check("bp_vec2_e0", {112'd0, oVData[BW-1:0]}, 128'd9);
        check("bp_vec2_e7", {112'd0, oVData[BW*NE-1 -: BW]}, 128'd16);
        check("bp_ready_back", {127'd0, oReady}, 128'd1);
        step(1'b0, 16'h0000, 1'b0, 1'b1);

        // Frame start on the fourth sample discards the partial frame
        do_reset();
        step(1'b1, 16'h0001, 1'b1, 1'b1);
        check("sof_first_nodrop", {127'd0, oDrop}, 128'd0);
        step(1'b1, 16'h0002, 1'b0, 1'b1);
        step(1'b1, 16'h0003, 1'b0, 1'b1);
        step(1'b1, 16'h000A, 1'b1, 1'b1);
        check("sof_drop", {127'd0, oDrop}, 128'd1);
        for (int i = 0; i < NE - 1; i++) step(1'b1, BW'(16'h000B + i), 1'b0, 1'b1);
        check("sof_nd", {127'd0, oND}, 128'd1);
        check("sof_e0", {112'd0, oVData[BW-1:0]}, 128'h000A);
        step(1'b0, 16'h0000, 1'b0, 1'b1);

        // Reset in the middle of a frame
        for (int i = 0; i < 5; i++) step(1'b1, BW'(16'h0100 + i), 1'b0, 1'b1);
        do_reset();
        check("rst_vdata", oVData, 128'd0);
        for (int i = 0; i < NE; i++) step(1'b1, BW'(16'h0200 + i), 1'b0, 1'b1);
        check("rst_nd", {127'd0, oND}, 128'd1);
        check("rst_e3", {112'd0, oVData[3*BW +: BW]}, 128'h0203);

        // 64 samples at full rate
        nvec = 0;
        for (int i = 0; i < 64; i++) begin
            step(1'b1, BW'($urandom), 1'b0, 1'b1);
            if (oND) nvec++;
        end
        check("stream_vectors", {96'd0, 32'(nvec)}, 128'd8);

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            step($urandom_range(0, 3) != 0, BW'($urandom), $urandom_range(0, 7) == 0,
                 $urandom_range(0, 2) != 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
